snax_cgra_tcdm_bridge: RTL and testbench
========================================

SNAX_CGRA_TCDM_BRIDGE -- requirements
Module: snax_cgra_tcdm_bridge

Interface
REQ-001 SHALL have parameters: NumPorts, default 4, number of CGRA memory channels; CgraAddrWidth, default 6, CGRA word address; CgraDataWidth, default 16, CGRA payload; TcdmAddrWidth, default 48, TCDM byte address; TcdmDataWidth, default 64, TCDM word; RspFifoDepth, default 4, read-response entries per port (power of two, >=2).
REQ-002 SHALL use one clock, clk_i; reset rst_ni is asynchronous, active-low.
REQ-003 SHALL have ports, all per-port signals packed [NumPorts-1:0] of the stated width:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
enable_i  in  1  global accept enable
base_addr_i  in  TcdmAddrWidth  TCDM byte base
cgra_w_valid_i  in  1/port  waddr and wdata both present
cgra_waddr_i  in  CgraAddrWidth/port  write word address
cgra_wdata_i  in  CgraDataWidth/port  write payload
cgra_wpred_i  in  1/port  write predicate
cgra_w_ready_o  out  1/port  write accepted
cgra_r_valid_i  in  1/port  read address present
cgra_raddr_i  in  CgraAddrWidth/port  read word address
cgra_r_ready_o  out  1/port  read accepted
cgra_rdata_valid_o  out  1/port  response available
cgra_rdata_o  out  CgraDataWidth/port  response payload
cgra_rpred_o  out  1/port  response predicate
cgra_rdata_ready_i  in  1/port  CGRA consumes response
tcdm_q_valid_o  out  1/port  TCDM request valid
tcdm_q_ready_i  in  1/port  TCDM request ready
tcdm_q_write_o  out  1/port  1 = write
tcdm_q_addr_o  out  TcdmAddrWidth/port  byte address
tcdm_q_data_o  out  TcdmDataWidth/port  write data
tcdm_q_strb_o  out  TcdmDataWidth/8 per port  byte strobe
tcdm_p_valid_i  in  1/port  read response valid
tcdm_p_data_i  in  TcdmDataWidth/port  read response data
busy_o  out  1  any port active

Function
REQ-004 SHALL run an independent FSM per port: IDLE, WR_REQ, RD_REQ; request fields registered, stable while tcdm_q_valid_o high until q_ready.
REQ-005 SHALL assert tcdm_q_valid_o exactly in WR_REQ/RD_REQ; request issued the cycle after CGRA handshake (1-cycle latency).
REQ-006 SHALL compute tcdm_q_addr_o = base_addr_i + (addr << log2(TcdmDataWidth/8)), truncated to TcdmAddrWidth, sampled at CGRA handshake.
REQ-007 SHALL zero-extend write payload to TcdmDataWidth and drive tcdm_q_strb_o all-ones on writes, all-zeros on reads.
REQ-008 SHALL set cgra_w_ready_o = enable_i & (IDLE | q handshake this cycle); write with cgra_wpred_i=0 is consumed but issues no TCDM request (FSM stays/returns IDLE).
REQ-009 SHALL set cgra_r_ready_o = cgra_w_ready_o condition & !cgra_w_valid_i & credit>0; writes take priority over simultaneous reads.
REQ-010 SHALL track per port inflight (+1 read q handshake, -1 p_valid) and occupancy (+1 push, -1 pop); credit = RspFifoDepth - inflight - occupancy, never negative; simultaneous inc/dec net to zero.
REQ-011 SHALL push tcdm_p_data_i[CgraDataWidth-1:0] on p_valid when inflight>0; p_valid with inflight=0 ignored.
REQ-012 SHALL present FIFO head with cgra_rpred_o=1, in issue order; pop on valid&ready; push and pop same cycle when full or empty both legal.
REQ-013 SHALL, when enable_i falls, accept nothing new but complete pending requests and responses.
REQ-014 SHALL drive busy_o = any FSM not IDLE | any inflight>0 | any FIFO non-empty.

Reset
REQ-015 SHALL on rst_ni low immediately force FSMs IDLE, counters and FIFO pointers 0, all outputs 0 (busy_o 0, ready 0); mid-transaction requests and buffered data discarded.

Configuration
REQ-016 SHALL, with SNAX_CGRA_BRIDGE_PERF_EN defined, add output perf_stall_cnt_o (32 bits/port) counting cycles tcdm_q_valid_o & !tcdm_q_ready_i, saturating at 2^32-1, reset 0; without macro, port and logic absent, behaviour otherwise identical.

Verification
REQ-017 Write: base 0x1000, port 2 waddr 5, data 0xBEEF, pred 1, q_ready 1 -> next cycle q_valid, addr 0x1028, data 0x...BEEF, strb 0xFF, write 1.
REQ-018 Predicated-off write: pred 0 -> w_ready 1, no tcdm_q_valid_o on any later cycle.
REQ-019 Credit: RspFifoDepth 4, rdata_ready 0, six back-to-back reads -> exactly four issued, r_ready low afterwards; pop one -> one more issued.
REQ-020 Backpressure: q_ready 0 for 3 cycles -> addr/data stable 3 cycles, perf counter 3 with macro.
REQ-021 Priority: w_valid and r_valid same cycle -> write issued first, read next.
REQ-022 Reset mid-read: assert rst_ni low with 2 inflight -> all outputs 0, busy_o 0 same cycle; later p_valid ignored.

Source files
------------

// File: rtl/snax_cgra_tcdm_bridge.sv
// snax_cgra_tcdm_bridge: per-port CGRA memory channels to TCDM requests.
// Define SNAX_CGRA_BRIDGE_PERF_EN to add per-port TCDM stall counters.
module snax_cgra_tcdm_bridge #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned CgraAddrWidth = 6,
    parameter int unsigned CgraDataWidth = 16,
    parameter int unsigned TcdmAddrWidth = 48,
    parameter int unsigned TcdmDataWidth = 64,
    parameter int unsigned RspFifoDepth  = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         enable_i,
    input  logic [TcdmAddrWidth-1:0]                     base_addr_i,
    input  logic [NumPorts-1:0]                          cgra_w_valid_i,
    input  logic [NumPorts-1:0][CgraAddrWidth-1:0]       cgra_waddr_i,
    input  logic [NumPorts-1:0][CgraDataWidth-1:0]       cgra_wdata_i,
    input  logic [NumPorts-1:0]                          cgra_wpred_i,
    output logic [NumPorts-1:0]                          cgra_w_ready_o,
    input  logic [NumPorts-1:0]                          cgra_r_valid_i,
    input  logic [NumPorts-1:0][CgraAddrWidth-1:0]       cgra_raddr_i,
    output logic [NumPorts-1:0]                          cgra_r_ready_o,
    output logic [NumPorts-1:0]                          cgra_rdata_valid_o,
    output logic [NumPorts-1:0][CgraDataWidth-1:0]       cgra_rdata_o,
    output logic [NumPorts-1:0]                          cgra_rpred_o,
    input  logic [NumPorts-1:0]                          cgra_rdata_ready_i,
    output logic [NumPorts-1:0]                          tcdm_q_valid_o,
    input  logic [NumPorts-1:0]                          tcdm_q_ready_i,
    output logic [NumPorts-1:0]                          tcdm_q_write_o,
    output logic [NumPorts-1:0][TcdmAddrWidth-1:0]       tcdm_q_addr_o,
    output logic [NumPorts-1:0][TcdmDataWidth-1:0]       tcdm_q_data_o,
    output logic [NumPorts-1:0][TcdmDataWidth/8-1:0]     tcdm_q_strb_o,
    input  logic [NumPorts-1:0]                          tcdm_p_valid_i,
    input  logic [NumPorts-1:0][TcdmDataWidth-1:0]       tcdm_p_data_i,
    output logic                                         busy_o
`ifdef SNAX_CGRA_BRIDGE_PERF_EN
    ,
    output logic [NumPorts-1:0][31:0]                    perf_stall_cnt_o
`endif
);

    localparam int unsigned StrbW = TcdmDataWidth / 8;
    localparam int unsigned Shift = $clog2(StrbW);
    localparam int unsigned PtrW  = $clog2(RspFifoDepth);
    localparam int unsigned CntW  = $clog2(RspFifoDepth + 1);
    localparam logic [CntW-1:0] Depth = CntW'(RspFifoDepth);

    typedef enum logic [1:0] {
        IDLE,
        WR_REQ,
        RD_REQ
    } state_e;

    logic [NumPorts-1:0] port_busy;

    assign busy_o = |port_busy;

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        state_e                   state_q;
        logic                     q_valid_q;
        logic                     q_write_q;
        logic [TcdmAddrWidth-1:0] q_addr_q;
        logic [TcdmDataWidth-1:0] q_data_q;
        logic [StrbW-1:0]         q_strb_q;
        logic [CntW-1:0]          infl_q;
        logic [CntW-1:0]          occ_q;
        logic [CntW-1:0]          credit;
        logic [PtrW-1:0]          wptr_q;
        logic [PtrW-1:0]          rptr_q;
        logic [CgraDataWidth-1:0] mem_q [RspFifoDepth];
        logic                     q_hs;
        logic                     rd_hs;
        logic                     rd_pend;
        logic                     accept;
        logic                     rd_ok;
        logic                     w_fire;
        logic                     r_fire;
        logic                     push;
        logic                     pop;
        logic                     has_rsp;
        logic [CgraAddrWidth-1:0] sel_addr;
        logic [TcdmAddrWidth-1:0] byte_addr;

        assign q_hs    = q_valid_q & tcdm_q_ready_i[i];
        assign rd_hs   = q_hs & ~q_write_q;
        // A read waiting in RD_REQ already owns a response slot.
        assign rd_pend = (state_q == RD_REQ);
        assign credit  = Depth - infl_q - occ_q - CntW'(rd_pend);
        assign accept  = rst_ni & enable_i
                       & ((state_q == IDLE) | q_hs);
        assign rd_ok   = accept & ~cgra_w_valid_i[i]
                       & (credit != '0);
        assign w_fire  = cgra_w_valid_i[i] & accept;
        assign r_fire  = cgra_r_valid_i[i] & rd_ok;
        assign push    = tcdm_p_valid_i[i] & (infl_q != '0);
        assign has_rsp = (occ_q != '0);
        assign pop     = cgra_rdata_ready_i[i] & has_rsp;

        assign sel_addr  = cgra_w_valid_i[i] ? cgra_waddr_i[i]
                                             : cgra_raddr_i[i];
        assign byte_addr = base_addr_i
                         + (TcdmAddrWidth'(sel_addr) << Shift);

        assign cgra_w_ready_o[i]     = accept;
        assign cgra_r_ready_o[i]     = rd_ok;
        assign tcdm_q_valid_o[i]     = q_valid_q;
        assign tcdm_q_write_o[i]     = q_write_q;
        assign tcdm_q_addr_o[i]      = q_addr_q;
        assign tcdm_q_data_o[i]      = q_data_q;
        assign tcdm_q_strb_o[i]      = q_strb_q;
        assign cgra_rdata_valid_o[i] = has_rsp;
        assign cgra_rpred_o[i]       = has_rsp;
        assign cgra_rdata_o[i]       = has_rsp ? mem_q[rptr_q] : '0;
        assign port_busy[i]          = (state_q != IDLE)
                                     | (infl_q != '0) | has_rsp;

        // Request FSM: take one CGRA access, hold it until TCDM takes it.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q   <= IDLE;
                q_valid_q <= 1'b0;
                q_write_q <= 1'b0;
                q_addr_q  <= '0;
                q_data_q  <= '0;
                q_strb_q  <= '0;
            end else begin
                unique case (1'b1)
                    w_fire && cgra_wpred_i[i]: begin
                        state_q   <= WR_REQ;
                        q_valid_q <= 1'b1;
                        q_write_q <= 1'b1;
                        q_addr_q  <= byte_addr;
                        q_data_q  <= TcdmDataWidth'(cgra_wdata_i[i]);
                        q_strb_q  <= '1;
                    end
                    w_fire && !cgra_wpred_i[i]: begin
                        state_q   <= IDLE;
                        q_valid_q <= 1'b0;
                    end
                    r_fire: begin
                        state_q   <= RD_REQ;
                        q_valid_q <= 1'b1;
                        q_write_q <= 1'b0;
                        q_addr_q  <= byte_addr;
                        q_data_q  <= '0;
                        q_strb_q  <= '0;
                    end
                    q_hs && !w_fire && !r_fire: begin
                        state_q   <= IDLE;
                        q_valid_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        // Track issued-but-unanswered reads and buffered responses.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                infl_q <= '0;
                occ_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (rd_hs && !push) begin
                    infl_q <= infl_q + CntW'(1);
                end else if (!rd_hs && push) begin
                    infl_q <= infl_q - CntW'(1);
                end
                if (push && !pop) begin
                    occ_q <= occ_q + CntW'(1);
                end else if (!push && pop) begin
                    occ_q <= occ_q - CntW'(1);
                end
                if (push) begin
                    wptr_q <= wptr_q + PtrW'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PtrW'(1);
                end
            end
        end

        // Response storage; contents are only visible while occupied.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wptr_q] <= tcdm_p_data_i[i][CgraDataWidth-1:0];
            end
        end

        if (TcdmDataWidth > CgraDataWidth) begin : g_hi
            logic unused_p_hi;
            assign unused_p_hi =
                ^tcdm_p_data_i[i][TcdmDataWidth-1:CgraDataWidth];
        end

`ifdef SNAX_CGRA_BRIDGE_PERF_EN
        logic [31:0] stall_q;

        // Count cycles a request waits on TCDM, saturating at max.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_q <= '0;
            end else if (q_valid_q && !tcdm_q_ready_i[i]
                         && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end

        assign perf_stall_cnt_o[i] = stall_q;
`endif
    end

endmodule

// File: tb/tb_snax_cgra_tcdm_bridge.sv
// tb_snax_cgra_tcdm_bridge: directed vectors for the CGRA/TCDM bridge.
// Perf counter checks are active when SNAX_CGRA_BRIDGE_PERF_EN is defined.
module tb_snax_cgra_tcdm_bridge;

    localparam int NP  = 4;
    localparam int CAW = 6;
    localparam int CDW = 16;
    localparam int TAW = 48;
    localparam int TDW = 64;
    localparam int DEP = 4;

    logic                      clk = 1'b0;
    logic                      rst_ni;
    logic                      enable_i;
    logic [TAW-1:0]            base_addr;
    logic [NP-1:0]             w_valid, wpred, w_ready;
    logic [NP-1:0]             r_valid, r_ready;
    logic [NP-1:0]             rd_valid, rpred, rd_ready;
    logic [NP-1:0]             q_valid, q_ready, q_write;
    logic [NP-1:0]             p_valid;
    logic [NP-1:0][CAW-1:0]    waddr, raddr;
    logic [NP-1:0][CDW-1:0]    wdata, rdata;
    logic [NP-1:0][TAW-1:0]    q_addr;
    logic [NP-1:0][TDW-1:0]    q_data, p_data;
    logic [NP-1:0][TDW/8-1:0]  q_strb;
    logic                      busy;
`ifdef SNAX_CGRA_BRIDGE_PERF_EN
    logic [NP-1:0][31:0]       perf;
`endif

    snax_cgra_tcdm_bridge #(
        .NumPorts      (NP),
        .CgraAddrWidth (CAW),
        .CgraDataWidth (CDW),
        .TcdmAddrWidth (TAW),
        .TcdmDataWidth (TDW),
        .RspFifoDepth  (DEP)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .enable_i           (enable_i),
        .base_addr_i        (base_addr),
        .cgra_w_valid_i     (w_valid),
        .cgra_waddr_i       (waddr),
        .cgra_wdata_i       (wdata),
        .cgra_wpred_i       (wpred),
        .cgra_w_ready_o     (w_ready),
        .cgra_r_valid_i     (r_valid),
        .cgra_raddr_i       (raddr),
        .cgra_r_ready_o     (r_ready),
        .cgra_rdata_valid_o (rd_valid),
        .cgra_rdata_o       (rdata),
        .cgra_rpred_o       (rpred),
        .cgra_rdata_ready_i (rd_ready),
        .tcdm_q_valid_o     (q_valid),
        .tcdm_q_ready_i     (q_ready),
        .tcdm_q_write_o     (q_write),
        .tcdm_q_addr_o      (q_addr),
        .tcdm_q_data_o      (q_data),
        .tcdm_q_strb_o      (q_strb),
        .tcdm_p_valid_i     (p_valid),
        .tcdm_p_data_i      (p_data),
        .busy_o             (busy)
`ifdef SNAX_CGRA_BRIDGE_PERF_EN
        ,
        .perf_stall_cnt_o   (perf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int             port;
        logic [TAW-1:0] base;
        logic [CAW-1:0] addr;
        logic [CDW-1:0] data;
        logic           pred;
        logic           exp_v;
        logic [TAW-1:0] exp_addr;
        logic [TDW-1:0] exp_data;
    } wvec_t;

    wvec_t wv[5];
    int    n_chk = 0;
    int    n_fail = 0;
    int    acc;
    int    iss;
    int    p;
    logic [NP-1:0] ev;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wv[0] = '{2, 48'h1000, 6'd5, 16'hBEEF, 1'b1, 1'b1,
                  48'h1028, 64'h0000_0000_0000_BEEF};
        wv[1] = '{0, 48'h0, 6'd0, 16'h1234, 1'b1, 1'b1,
                  48'h0, 64'h1234};
        wv[2] = '{3, 48'hFFFF_FFFF_FFF8, 6'd1, 16'h8001, 1'b1, 1'b1,
                  48'h0, 64'h8001};
        wv[3] = '{1, 48'h2000, 6'd63, 16'hFFFF, 1'b1, 1'b1,
                  48'h21F8, 64'hFFFF};
        wv[4] = '{1, 48'h3000, 6'd7, 16'h5555, 1'b0, 1'b0,
                  48'h0, 64'h0};

        rst_ni    = 1'b0;
        enable_i  = 1'b1;
        base_addr = '0;
        w_valid   = '0;
        wpred     = '0;
        waddr     = '0;
        wdata     = '0;
        r_valid   = '0;
        raddr     = '0;
        rd_ready  = '0;
        q_ready   = '1;
        p_valid   = '0;
        p_data    = '0;

        // reset state
        #12;
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_r_ready", 64'(r_ready), 64'd0);
        check("rst_q_valid", 64'(q_valid), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        #1;
        check("idle_w_ready", 64'(w_ready), 64'hF);
        check("idle_r_ready", 64'(r_ready), 64'hF);

        // write vectors
        foreach (wv[k]) begin
            p = wv[k].port;
            base_addr  = wv[k].base;
            w_valid[p] = 1'b1;
            waddr[p]   = wv[k].addr;
            wdata[p]   = wv[k].data;
            wpred[p]   = wv[k].pred;
            #1;
            check("wr_w_ready", 64'(w_ready[p]), 64'd1);
            check("wr_r_ready", 64'(r_ready[p]), 64'd0);
            tick();
            w_valid = '0;
            ev = '0;
            ev[p] = wv[k].exp_v;
            check("wr_q_valid", 64'(q_valid), 64'(ev));
            if (wv[k].exp_v) begin
                check("wr_q_addr", 64'(q_addr[p]), 64'(wv[k].exp_addr));
                check("wr_q_data", q_data[p], wv[k].exp_data);
                check("wr_q_strb", 64'(q_strb[p]), 64'hFF);
                check("wr_q_write", 64'(q_write[p]), 64'd1);
            end
            tick();
            check("wr_done_q_valid", 64'(q_valid), 64'd0);
            check("wr_done_busy", 64'(busy), 64'd0);
        end

        // credit limit on port 0
        base_addr  = 48'h1000;
        raddr[0]   = 6'd3;
        r_valid[0] = 1'b1;
        acc = 0;
        iss = 0;
        repeat (10) begin
            @(negedge clk);
            if (r_valid[0] && r_ready[0]) acc++;
            if (q_valid[0] && q_ready[0] && !q_write[0]) iss++;
        end
        check("cr_accepted", 64'(acc), 64'd4);
        check("cr_issued", 64'(iss), 64'd4);
        check("cr_r_ready_low", 64'(r_ready[0]), 64'd0);
        check("cr_rd_addr", 64'(q_addr[0]), 64'h1018);
        check("cr_rd_strb", 64'(q_strb[0]), 64'd0);
        check("cr_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            p_valid[0] = 1'b1;
            p_data[0]  = 64'hDEAD_0000_0000_A000 + 64'(k);
        end
        tick();
        p_valid = '0;
        @(negedge clk);
        check("cr_full_r_ready", 64'(r_ready[0]), 64'd0);
        check("cr_head_valid", 64'(rd_valid[0]), 64'd1);
        check("cr_head_data", 64'(rdata[0]), 64'hA000);
        check("cr_head_pred", 64'(rpred[0]), 64'd1);
        tick();
        rd_ready[0] = 1'b1;
        tick();
        rd_ready[0] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (r_valid[0] && r_ready[0]) acc++;
            if (q_valid[0] && q_ready[0] && !q_write[0]) iss++;
        end
        check("cr_pop_accepted", 64'(acc), 64'd5);
        check("cr_pop_issued", 64'(iss), 64'd5);
        check("cr_pop_r_ready_low", 64'(r_ready[0]), 64'd0);
        tick();
        r_valid[0] = 1'b0;
        p_valid[0] = 1'b1;
        p_data[0]  = 64'hDEAD_0000_0000_A004;
        tick();
        p_valid = '0;
        rd_ready[0] = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("cr_fifo_order", 64'(rdata[0]), 64'hA000 + 64'(k));
        end
        tick();
        rd_ready[0] = 1'b0;
        check("cr_drained_valid", 64'(rd_valid[0]), 64'd0);
        check("cr_drained_data", 64'(rdata[0]), 64'd0);
        check("cr_drained_busy", 64'(busy), 64'd0);

        // backpressure on port 1 with enable dropped
        base_addr  = 48'h2000;
        q_ready[1] = 1'b0;
        w_valid[1] = 1'b1;
        waddr[1]   = 6'd2;
        wdata[1]   = 16'h1111;
        wpred[1]   = 1'b1;
        tick();
        w_valid    = '0;
        enable_i   = 1'b0;
        r_valid[2] = 1'b1;
        raddr[2]   = 6'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_q_valid", 64'(q_valid[1]), 64'd1);
            check("bp_q_addr", 64'(q_addr[1]), 64'h2010);
            check("bp_q_data", q_data[1], 64'h1111);
            check("bp_w_ready_off", 64'(w_ready[1]), 64'd0);
            check("bp_r_ready_off", 64'(r_ready[2]), 64'd0);
            check("bp_no_new_req", 64'(q_valid[2]), 64'd0);
        end
        @(posedge clk);
        #1 q_ready[1] = 1'b1;
        tick();
        check("bp_done_q_valid", 64'(q_valid[1]), 64'd0);
        check("bp_done_busy", 64'(busy), 64'd0);
`ifdef SNAX_CGRA_BRIDGE_PERF_EN
        check("bp_perf", 64'(perf[1]), 64'd3);
`endif
        r_valid  = '0;
        enable_i = 1'b1;
        #1;
        check("bp_reenable", 64'(w_ready[1]), 64'd1);

        // write beats read on port 3
        base_addr  = 48'h1000;
        w_valid[3] = 1'b1;
        waddr[3]   = 6'd1;
        wdata[3]   = 16'h7777;
        wpred[3]   = 1'b1;
        r_valid[3] = 1'b1;
        raddr[3]   = 6'd2;
        #1;
        check("pr_w_ready", 64'(w_ready[3]), 64'd1);
        check("pr_r_ready", 64'(r_ready[3]), 64'd0);
        tick();
        w_valid = '0;
        #1;
        check("pr_wr_valid", 64'(q_valid[3]), 64'd1);
        check("pr_wr_write", 64'(q_write[3]), 64'd1);
        check("pr_wr_addr", 64'(q_addr[3]), 64'h1008);
        check("pr_rd_ready", 64'(r_ready[3]), 64'd1);
        tick();
        r_valid = '0;
        check("pr_rd_valid", 64'(q_valid[3]), 64'd1);
        check("pr_rd_write", 64'(q_write[3]), 64'd0);
        check("pr_rd_addr", 64'(q_addr[3]), 64'h1010);
        tick();
        check("pr_inflight_busy", 64'(busy), 64'd1);
        p_valid[3] = 1'b1;
        p_data[3]  = 64'hFFFF_FFFF_FFFF_CAFE;
        tick();
        p_valid = '0;
        check("pr_rsp_valid", 64'(rd_valid[3]), 64'd1);
        check("pr_rsp_data", 64'(rdata[3]), 64'hCAFE);
        rd_ready[3] = 1'b1;
        tick();
        rd_ready = '0;
        check("pr_done_busy", 64'(busy), 64'd0);

        // reset with two reads outstanding on port 0
        raddr[0]   = 6'd4;
        r_valid[0] = 1'b1;
        tick();
        tick();
        r_valid = '0;
        tick();
        check("rr_pre_busy", 64'(busy), 64'd1);
        w_valid[1] = 1'b1;
        wpred[1]   = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        check("rr_w_ready", 64'(w_ready), 64'd0);
        check("rr_r_ready", 64'(r_ready), 64'd0);
        check("rr_q_valid", 64'(q_valid), 64'd0);
        check("rr_q_write", 64'(q_write), 64'd0);
        check("rr_q_addr", 64'(|q_addr), 64'd0);
        check("rr_q_data", 64'(|q_data), 64'd0);
        check("rr_rd_valid", 64'(rd_valid), 64'd0);
        check("rr_busy", 64'(busy), 64'd0);
        w_valid = '0;
        tick();
        rst_ni = 1'b1;
        p_valid[0] = 1'b1;
        p_data[0]  = 64'h5A5A;
        tick();
        p_valid = '0;
        check("rr_stale_rsp", 64'(rd_valid[0]), 64'd0);
        check("rr_stale_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
